iq_pair_scheduler: RTL and testbench

- Round-robin scheduler that time-shares one IQ deinterleaver/scaling datapath between nch requesting channels.
- Each requester offers one I/Q sample pair. The scheduler serialises the pair as I then Q, with iq_sel and that channel's scale factor presented on the same cycle as the data.
- It tracks datapath latency so a channel tag emerges aligned with the deinterleaver's valid_out.
- It sits between per-channel CIC/decimator outputs and the shared deinterleaver.

---
 rtl/iq_sched_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/iq_pair_scheduler.sv | 124 ++++++++++++
 tb/tb_iq_pair_scheduler.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/iq_sched_pkg.sv
// Shared types and helpers for the IQ pair scheduler: FSM state encoding and
// the scale-factor clamp that keeps full-scale negative out of the datapath.
package iq_sched_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEND_I = 2'd1,
      SEND_Q = 2'd2
   } sched_state_e;

   localparam int SCALE_MAX_WI = 32;

   // The most negative scale value cannot be negated symmetrically, so it is
   // nudged up by one; v holds a wi-bit value sign-extended to 32 bits.
   function automatic logic [SCALE_MAX_WI-1:0] clamp_scale(input logic [SCALE_MAX_WI-1:0] v,
                                                           input int wi);
      logic [SCALE_MAX_WI-1:0] most_neg;
      most_neg = {SCALE_MAX_WI{1'b1}} << (wi - 1);
      return (v == most_neg) ? v + 32'd1 : v;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant on the first request at or
// after the pointer, wrapping modulo nch, plus the binary index of the winner.
module rr_arbiter #(
   parameter int nch = 4,
   localparam int cw = $clog2(nch)
) (
   input  logic [nch-1:0] req_i,
   input  logic [cw-1:0]  ptr_i,
   output logic [nch-1:0] grant_o,
   output logic [cw-1:0]  idx_o,
   output logic           valid_o
);

   logic [cw-1:0] cand;

   // Scan from the farthest offset down so the closest requester wins last.
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      cand    = '0;
      for (int off = nch - 1; off >= 0; off--) begin
         cand = cw'((int'(ptr_i) + off) % nch);
         if (req_i[cand]) begin
            grant_o       = '0;
            grant_o[cand] = 1'b1;
            idx_o         = cand;
            valid_o       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/iq_pair_scheduler.sv
// Round-robin scheduler sharing one IQ deinterleaver between nch channels:
// serialises each granted pair as I then Q and tags it through the datapath latency.
module iq_pair_scheduler
   import iq_sched_pkg::*;
#(
   parameter int nch       = 4,
   parameter int dwi       = 16,
   parameter int scale_wi  = 18,
   parameter int lat       = 4,
   parameter int scale_rst = 2 ** (scale_wi - 2),
   localparam int cw       = $clog2(nch)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [nch-1:0]      req,
   input  logic [nch*dwi-1:0]  i_in,
   input  logic [nch*dwi-1:0]  q_in,
   output logic [nch-1:0]      ack,
   input  logic                cfg_we,
   input  logic [cw-1:0]       cfg_addr,
   input  logic [scale_wi-1:0] cfg_data,
   output logic [dwi-1:0]      iq_data,
   output logic                iq_sel,
   output logic [scale_wi-1:0] scale_out,
   output logic                tag_valid,
   output logic [cw-1:0]       tag_chan,
   output logic                busy
);

   sched_state_e        state_q;
   logic [cw-1:0]       ptr_q, ptr_d, chan_q, gnt_idx;
   logic [nch-1:0]      gnt;
   logic                gnt_valid, arb_en, take;
   logic [dwi-1:0]      iq_data_q, q_q;
   logic                iq_sel_q;
   logic [scale_wi-1:0] scale_out_q, scale_wr_d;
   logic [scale_wi-1:0] scale_q [nch];
   logic [lat-1:0]      tag_v_q;
   logic [cw-1:0]       tag_c_q [lat];

   rr_arbiter #(.nch(nch)) u_arb (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .grant_o (gnt),
      .idx_o   (gnt_idx),
      .valid_o (gnt_valid)
   );

   // A new pair may start only when the datapath input slot after this cycle is free.
   assign arb_en     = (state_q == IDLE) || (state_q == SEND_Q);
   assign take       = arb_en && gnt_valid;
   assign ack        = take ? gnt : '0;
   assign ptr_d      = (gnt_idx == cw'(nch - 1)) ? '0 : gnt_idx + cw'(1);
   assign scale_wr_d = scale_wi'(clamp_scale(SCALE_MAX_WI'(signed'(cfg_data)), scale_wi));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         chan_q      <= '0;
         q_q         <= '0;
         iq_data_q   <= '0;
         iq_sel_q    <= 1'b0;
         scale_out_q <= '0;
      end else begin
         case (state_q)
            SEND_I: begin
               state_q   <= SEND_Q;
               iq_data_q <= q_q;
               iq_sel_q  <= 1'b0;
            end
            IDLE, SEND_Q: begin
               if (take) begin
                  state_q     <= SEND_I;
                  iq_data_q   <= i_in[int'(gnt_idx)*dwi +: dwi];
                  q_q         <= q_in[int'(gnt_idx)*dwi +: dwi];
                  scale_out_q <= scale_q[gnt_idx];
                  chan_q      <= gnt_idx;
                  ptr_q       <= ptr_d;
                  iq_sel_q    <= 1'b1;
               end else begin
                  state_q     <= IDLE;
                  iq_data_q   <= '0;
                  iq_sel_q    <= 1'b0;
                  scale_out_q <= '0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // The grant reads scale_q before this edge's write lands, so a pair never tears.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < nch; k++) scale_q[k] <= scale_wi'(scale_rst);
      end else if (cfg_we && (int'(cfg_addr) < nch)) begin
         scale_q[cfg_addr] <= scale_wr_d;
      end
   end

   // Tag entry is made while I sits at the datapath input, so it pops out lat cycles later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_v_q <= '0;
         for (int k = 0; k < lat; k++) tag_c_q[k] <= '0;
      end else begin
         for (int k = lat - 1; k > 0; k--) begin
            tag_v_q[k] <= tag_v_q[k-1];
            tag_c_q[k] <= tag_c_q[k-1];
         end
         tag_v_q[0] <= (state_q == SEND_I);
         tag_c_q[0] <= chan_q;
      end
   end

   assign iq_data   = iq_data_q;
   assign iq_sel    = iq_sel_q;
   assign scale_out = scale_out_q;
   assign tag_valid = tag_v_q[lat-1];
   assign tag_chan  = tag_c_q[lat-1];
   assign busy      = (state_q != IDLE) || (|tag_v_q);

endmodule

// File: tb/tb_iq_pair_scheduler.sv
// Self-checking bench for iq_pair_scheduler: directed scenarios plus a random
// phase, all scored against a time-indexed expectation schedule.
module tb_iq_pair_scheduler;

   localparam int NCH  = 4;
   localparam int DWI  = 16;
   localparam int SWI  = 18;
   localparam int LAT  = 4;
   localparam int CW   = 2;
   localparam int NCYC = 1024;
   localparam logic [SWI-1:0] SRST = 18'h10000;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NCH-1:0]    req;
   logic [NCH*DWI-1:0] i_in, q_in;
   logic [NCH-1:0]    ack;
   logic              cfg_we;
   logic [CW-1:0]     cfg_addr;
   logic [SWI-1:0]    cfg_data;
   logic [DWI-1:0]    iq_data;
   logic              iq_sel;
   logic [SWI-1:0]    scale_out;
   logic              tag_valid;
   logic [CW-1:0]     tag_chan;
   logic              busy;

   always #5 clk = ~clk;

   iq_pair_scheduler #(
      .nch(NCH), .dwi(DWI), .scale_wi(SWI), .lat(LAT), .scale_rst(2 ** (SWI - 2))
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .i_in(i_in), .q_in(q_in), .ack(ack),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .iq_data(iq_data), .iq_sel(iq_sel), .scale_out(scale_out),
      .tag_valid(tag_valid), .tag_chan(tag_chan), .busy(busy)
   );

   int nAsserts = 0;
   int nFails   = 0;
   int cyc      = 0;
   int mPtr     = 0;
   int lastGrant = -10;
   int gnt;
   logic we;
   logic [NCH-1:0] pend;
   int order[$];

   logic [SWI-1:0] mScale [NCH];
   logic [DWI-1:0] eData  [NCYC];
   logic           eSel   [NCYC];
   logic [SWI-1:0] eScale [NCYC];
   logic           eTagV  [NCYC];
   logic [CW-1:0]  eTagC  [NCYC];
   logic           eBusy  [NCYC];

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFails++;
         $error("[TB] FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic int pickChannel(input logic [NCH-1:0] r);
      for (int off = 0; off < NCH; off++)
         if (r[(mPtr + off) % NCH]) return (mPtr + off) % NCH;
      return -1;
   endfunction

   task automatic clearModel(input int from);
      for (int c = from; c < NCYC; c++) begin
         eData[c] = '0; eSel[c] = 1'b0; eScale[c] = '0;
         eTagV[c] = 1'b0; eTagC[c] = '0; eBusy[c] = 1'b0;
      end
   endtask

   task automatic resetModel();
      mPtr = 0;
      lastGrant = -10;
      for (int k = 0; k < NCH; k++) mScale[k] = SRST;
   endtask

   // Drives one cycle of inputs, scores the outputs, then books the pair's future outputs.
   task automatic applyStimulus(input logic [NCH-1:0] r, input logic w, input logic [CW-1:0] a,
                                input logic [SWI-1:0] d, output int g);
      req = r; cfg_we = w; cfg_addr = a; cfg_data = d;
      @(negedge clk);
      g = (cyc != lastGrant + 1) ? pickChannel(r) : -1;
      checkOutput("ack", 32'(ack), (g >= 0) ? (32'd1 << g) : 32'd0);
      checkOutput("iq_data", 32'(iq_data), 32'(eData[cyc]));
      checkOutput("iq_sel", 32'(iq_sel), 32'(eSel[cyc]));
      checkOutput("scale_out", 32'(scale_out), 32'(eScale[cyc]));
      checkOutput("tag_valid", 32'(tag_valid), 32'(eTagV[cyc]));
      if (eTagV[cyc]) checkOutput("tag_chan", 32'(tag_chan), 32'(eTagC[cyc]));
      checkOutput("busy", 32'(busy), 32'(eBusy[cyc]));
      if (g >= 0) begin
         lastGrant = cyc;
         mPtr = (g + 1) % NCH;
         eData[cyc+1]  = i_in[g*DWI +: DWI];
         eSel[cyc+1]   = 1'b1;
         eData[cyc+2]  = q_in[g*DWI +: DWI];
         eScale[cyc+1] = mScale[g];
         eScale[cyc+2] = mScale[g];
         eTagV[cyc+1+LAT] = 1'b1;
         eTagC[cyc+1+LAT] = CW'(g);
         for (int k = 1; k <= 1 + LAT; k++) eBusy[cyc+k] = 1'b1;
      end
      if (w) mScale[a] = (d == 18'h20000) ? 18'h20001 : d;
      @(posedge clk); #1;
      cyc++;
   endtask

   task automatic pulseReset();
      rst_n = 1'b0; req = '0; cfg_we = 1'b0;
      #1;
      checkOutput("rst_ack", 32'(ack), 32'd0);
      checkOutput("rst_iq_data", 32'(iq_data), 32'd0);
      checkOutput("rst_iq_sel", 32'(iq_sel), 32'd0);
      checkOutput("rst_scale_out", 32'(scale_out), 32'd0);
      checkOutput("rst_tag_valid", 32'(tag_valid), 32'd0);
      checkOutput("rst_tag_chan", 32'(tag_chan), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      resetModel();
      clearModel(cyc + 1);
      @(posedge clk); #1;
      cyc++;
   endtask

   task automatic idleCycles(input int n);
      int g;
      for (int k = 0; k < n; k++) applyStimulus('0, 1'b0, '0, '0, g);
   endtask

   initial begin
      req = '0; i_in = '0; q_in = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
      pend = '0; we = 1'b0;
      clearModel(0);
      resetModel();
      repeat (2) @(posedge clk);
      #1;
      pulseReset();

      $display("[TB] single pair on ch0");
      i_in[0 +: DWI] = 16'd100;
      q_in[0 +: DWI] = 16'hFFCE;
      applyStimulus(4'b0001, 1'b0, '0, '0, gnt);
      checkOutput("t1_I_data", 32'(iq_data), 32'd100);
      checkOutput("t1_I_sel", 32'(iq_sel), 32'd1);
      applyStimulus('0, 1'b0, '0, '0, gnt);
      checkOutput("t1_Q_data", 32'(iq_data), 32'h0000FFCE);
      idleCycles(6);

      $display("[TB] all channels requesting");
      pulseReset();
      for (int k = 0; k < NCH; k++) begin
         i_in[k*DWI +: DWI] = DWI'($urandom);
         q_in[k*DWI +: DWI] = DWI'($urandom);
      end
      for (int p = 0; p < 16; p++) begin
         applyStimulus(4'hF, 1'b0, '0, '0, gnt);
         if (gnt >= 0) begin
            order.push_back(gnt);
            i_in[gnt*DWI +: DWI] = DWI'($urandom);
            q_in[gnt*DWI +: DWI] = DWI'($urandom);
         end
      end
      checkOutput("rot_count", 32'(order.size()), 32'd8);
      for (int k = 0; k < 8 && k < order.size(); k++)
         checkOutput("rot_order", 32'(order[k]), 32'(k % 4));
      idleCycles(LAT + 2);

      $display("[TB] full-scale negative scale write");
      applyStimulus('0, 1'b1, 2'd2, 18'h20000, gnt);
      applyStimulus(4'b0100, 1'b0, '0, '0, gnt);
      checkOutput("fsneg_I", 32'(scale_out), 32'h20001);
      applyStimulus('0, 1'b0, '0, '0, gnt);
      checkOutput("fsneg_Q", 32'(scale_out), 32'h20001);
      idleCycles(LAT + 2);

      $display("[TB] scale write on grant edge");
      applyStimulus(4'b0010, 1'b1, 2'd1, 18'h01234, gnt);
      checkOutput("same_edge_old_I", 32'(scale_out), 32'(SRST));
      applyStimulus('0, 1'b0, '0, '0, gnt);
      checkOutput("same_edge_old_Q", 32'(scale_out), 32'(SRST));
      applyStimulus(4'b0010, 1'b0, '0, '0, gnt);
      checkOutput("same_edge_new", 32'(scale_out), 32'h01234);
      idleCycles(LAT + 2);

      $display("[TB] reset during SEND_Q of ch3");
      applyStimulus(4'b1000, 1'b0, '0, '0, gnt);
      applyStimulus('0, 1'b0, '0, '0, gnt);
      pulseReset();
      idleCycles(LAT + 1);
      applyStimulus(4'b1001, 1'b0, '0, '0, gnt);
      idleCycles(LAT + 2);

      $display("[TB] random traffic");
      for (int n = 0; n < 300; n++) begin
         for (int k = 0; k < NCH; k++) begin
            if (!pend[k]) begin
               if ($urandom_range(1, 0) == 1) begin
                  pend[k] = 1'b1;
                  i_in[k*DWI +: DWI] = DWI'($urandom);
                  q_in[k*DWI +: DWI] = DWI'($urandom);
               end
            end else if ($urandom_range(7, 0) == 0) begin
               pend[k] = 1'b0;
            end
         end
         we = ($urandom_range(9, 0) == 0);
         if (n == 150) pulseReset();
         applyStimulus(pend, we, CW'($urandom_range(NCH - 1, 0)),
                       ($urandom_range(3, 0) == 0) ? 18'h20000 : SWI'($urandom), gnt);
         if (gnt >= 0) pend[gnt] = 1'b0;
      end
      idleCycles(LAT + 2);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
